// File: rtl/pim_act_load_ctrl.sv
// Activation-buffer load sequencer: fetches NUM_WORDS words from memory into the PIM
// activation buffer, then holds the buffer output enabled while the macro computes.
module pim_act_load_ctrl #(
    parameter int unsigned NUM_WORDS = 9,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_buf_busy,
    output logic              o_buf_in_en,
    output logic [CNT_W-1:0]  o_buf_counter,
    output logic [31:0]       o_buf_data,
    output logic              o_buf_out_en,
    output logic              o_pim_start,
    input  logic              i_pim_done
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StWr,
        StStart,
        StCompute,
        StDone,
        StDrain
    } state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        data_d  = o_buf_data;
        unique case (state_q)
            StIdle: begin
                if (i_start && !i_abort) begin
                    state_d = StReq;
                    base_d  = i_base_addr;
                    idx_d   = '0;
                end
            end
            StReq: begin
                // A grant already issued must have its read data drained
                if (i_abort) begin
                    state_d = i_mem_gnt ? StDrain : StIdle;
                end else if (i_mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (i_abort) begin
                    state_d = StDrain;
                end else if (i_mem_rvalid) begin
                    data_d  = i_mem_rdata;
                    state_d = StWr;
                end
            end
            StWr: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else if (idx_q == LastIdx) begin
                    state_d = StStart;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = StReq;
                end
            end
            StStart:   state_d = i_abort ? StIdle : StCompute;
            StCompute: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else if (i_pim_done) begin
                    state_d = StDone;
                end
            end
            StDone:    state_d = StIdle;
            StDrain:   if (i_mem_rvalid) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            base_q        <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= '0;
            o_buf_busy    <= 1'b0;
            o_buf_in_en   <= 1'b0;
            o_buf_counter <= '0;
            o_buf_data    <= '0;
            o_buf_out_en  <= 1'b0;
            o_pim_start   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            base_q        <= base_d;
            o_busy        <= (state_d != StIdle);
            o_done        <= (state_d == StDone);
            o_mem_req     <= (state_d == StReq);
            o_mem_addr    <= (state_d == StReq) ? base_d + (ADDR_W'(idx_d) << 2) : '0;
            o_buf_busy    <= (state_d != StIdle) && (state_d != StDrain);
            o_buf_in_en   <= (state_d == StWr);
            o_buf_counter <= (state_d == StIdle) ? '0 : idx_d;
            o_buf_data    <= data_d;
            o_buf_out_en  <= (state_d == StStart) || (state_d == StCompute);
            o_pim_start   <= (state_d == StStart);
        end
    end

endmodule

// File: tb/tb_pim_act_load_ctrl.sv
// Scoreboard bench for pim_act_load_ctrl: randomized memory/macro responders, expected
// addresses and buffer writes queued per load, monitor pops on every DUT output event.
module tb_pim_act_load_ctrl;

    localparam int NumWords = 9;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_start, i_abort;
    logic [31:0] i_base_addr;
    logic        o_busy, o_done, o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_buf_busy, o_buf_in_en;
    logic [7:0]  o_buf_counter;
    logic [31:0] o_buf_data;
    logic        o_buf_out_en, o_pim_start, i_pim_done;
    logic        pim_done_auto, pim_done_man;
    logic [78:0] all_outs;

    assign i_pim_done = pim_done_auto | pim_done_man;
    assign all_outs = {o_busy, o_done, o_mem_req, o_mem_addr, o_buf_busy, o_buf_in_en,
                       o_buf_counter, o_buf_data, o_buf_out_en, o_pim_start};

    pim_act_load_ctrl #(.NUM_WORDS(NumWords), .ADDR_W(32), .CNT_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_base_addr  (i_base_addr),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_buf_busy   (o_buf_busy),
        .o_buf_in_en  (o_buf_in_en),
        .o_buf_counter(o_buf_counter),
        .o_buf_data   (o_buf_data),
        .o_buf_out_en (o_buf_out_en),
        .o_pim_start  (o_pim_start),
        .i_pim_done   (i_pim_done)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues and bookkeeping
    logic [31:0] exp_addr[$];
    logic [39:0] exp_wr[$];
    bit          exp_pim[$];
    bit          exp_done[$];
    int          gnt_cnt = 0, rv_cnt = 0, wr_cnt = 0;
    int unsigned start_cyc = 0, pim_cyc = 0, done_cyc = 0, pim_done_cyc = 0;

    // Responder configuration
    int          gnt_max = 0, rv_max = 0, pim_dly = 5;
    bit          rand_dly = 0, pim_auto = 1;
    logic [31:0] cur_base = '0, salt = '0;

    int          m_ph = 0, m_cnt = 0;
    logic [31:0] m_addr = '0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int m);
        return rand_dly ? int'($urandom_range(m, 0)) : m;
    endfunction

    // Memory model: data word = 0xA0 + word index from the load base + salt
    initial begin
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            i_mem_gnt = 1'b0;
            i_mem_rvalid = 1'b0;
            if (!i_rst_n) begin
                m_ph = 0;
            end else begin
                if (m_ph == 1 && !o_mem_req) m_ph = 0;
                if (m_ph == 0 && o_mem_req) begin
                    m_ph = 1;
                    m_cnt = pick(gnt_max);
                    m_addr = o_mem_addr;
                end
                if (m_ph == 1) begin
                    if (m_cnt == 0) begin
                        check_eq("req_addr_stable", o_mem_addr, m_addr);
                        i_mem_gnt = 1'b1;
                        gnt_cnt++;
                        m_ph = 2;
                        m_cnt = pick(rv_max);
                    end else begin
                        m_cnt--;
                    end
                end else if (m_ph == 2) begin
                    if (m_cnt == 0) begin
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata = ((m_addr - cur_base) >> 2) + 32'hA0 + salt;
                        rv_cnt++;
                        m_ph = 0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
    end

    // Macro model: pulse pim_done pim_dly cycles after pim_start
    initial begin
        pim_done_auto = 1'b0;
        forever begin
            @(negedge i_clk);
            #1;
            if (pim_auto && i_rst_n && o_pim_start) begin
                repeat (pim_dly) @(negedge i_clk);
                pim_done_auto = 1'b1;
                pim_done_cyc = cyc;
                @(negedge i_clk);
                pim_done_auto = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        logic [39:0] w;
        forever begin
            @(negedge i_clk);
            #1;
            if (i_rst_n) begin
                if (i_mem_gnt) begin
                    check_eq("gnt_expected", exp_addr.size() > 0, 1);
                    if (exp_addr.size() > 0) check_eq("mem_addr", o_mem_addr, exp_addr.pop_front());
                end
                if (o_buf_in_en) begin
                    wr_cnt++;
                    check_eq("wr_expected", exp_wr.size() > 0, 1);
                    if (exp_wr.size() > 0) begin
                        w = exp_wr.pop_front();
                        check_eq("wr_counter", o_buf_counter, w[39:32]);
                        check_eq("wr_data", o_buf_data, w[31:0]);
                    end
                end
                if (o_pim_start) begin
                    pim_cyc = cyc;
                    check_eq("pim_start_expected", exp_pim.size() > 0, 1);
                    if (exp_pim.size() > 0) void'(exp_pim.pop_front());
                    check_eq("pim_start_out_en", o_buf_out_en, 1);
                end
                if (o_done) begin
                    done_cyc = cyc;
                    check_eq("done_expected", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0) void'(exp_done.pop_front());
                    check_eq("done_out_en", o_buf_out_en, 0);
                    check_eq("done_buf_busy", o_buf_busy, 1);
                end
            end
        end
    end

    task automatic issue_load(input logic [31:0] base, input bit want_pim, input bit want_done);
        cur_base = base;
        for (int i = 0; i < NumWords; i++) begin
            exp_addr.push_back(base + 32'(4 * i));
            exp_wr.push_back({8'(i), 32'hA0 + 32'(i) + salt});
        end
        if (want_pim) exp_pim.push_back(1'b1);
        if (want_done) exp_done.push_back(1'b1);
        @(negedge i_clk);
        i_start = 1'b1;
        i_base_addr = base;
        start_cyc = cyc;
        @(negedge i_clk);
        i_start = 1'b0;
        i_base_addr = $urandom;
        #2;
        check_eq("req_one_cycle_after_start", o_mem_req, 1);
    endtask

    task automatic wait_done(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge i_clk);
            #2;
            got = o_done;
        end
        check_eq("wait_done", got, 1);
    endtask

    task automatic wait_pim_start(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge i_clk);
            #2;
            got = o_pim_start;
        end
        check_eq("wait_pim_start", got, 1);
    endtask

    task automatic clear_expect();
        exp_addr.delete();
        exp_wr.delete();
        exp_pim.delete();
        exp_done.delete();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        int g0, r0, w0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_base_addr = '0;
        pim_done_man = 1'b0;
        repeat (3) @(negedge i_clk);
        #2;
        check_eq("reset_outputs", $countones(all_outs), 0);
        i_rst_n = 1'b1;

        // Zero-wait memory, full load, latency and done timing
        w0 = wr_cnt;
        issue_load(32'h1000_0000, 1, 1);
        wait_pim_start(100);
        check_eq("pim_start_latency", pim_cyc - start_cyc, 28);
        wait_done(100);
        check_eq("done_after_pim_done", done_cyc - pim_done_cyc, 1);
        @(negedge i_clk);
        #2;
        check_eq("idle_after_done_busy", o_busy, 0);
        check_eq("idle_after_done_buf_busy", o_buf_busy, 0);
        check_eq("writes_zero_wait", wr_cnt - w0, NumWords);

        // Backpressure: grant delayed 3, data delayed 4
        gnt_max = 3;
        rv_max = 4;
        salt = 32'h100;
        w0 = wr_cnt;
        issue_load(32'h2000_0040, 1, 1);
        wait_done(400);
        check_eq("writes_backpressure", wr_cnt - w0, NumWords);

        // Abort in WAIT at idx 4, late data drained and discarded
        gnt_max = 0;
        rv_max = 6;
        salt = 32'h200;
        g0 = gnt_cnt;
        issue_load(32'h3000_0000, 0, 0);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge i_clk);
            #2;
            got = (gnt_cnt == g0 + 5);
        end
        check_eq("reach_idx4_grant", got, 1);
        clear_expect();
        @(negedge i_clk);
        r0 = rv_cnt;
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        #2;
        check_eq("drain_busy", o_busy, 1);
        check_eq("drain_buf_busy", o_buf_busy, 0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge i_clk);
            #2;
            got = !o_busy;
        end
        check_eq("drain_reaches_idle", got, 1);
        check_eq("drain_waited_rvalid", rv_cnt - r0, 1);
        rv_max = 0;
        issue_load(32'h3000_0100, 1, 1);
        wait_done(100);

        // Abort together with pim_done in COMPUTE
        pim_auto = 1'b0;
        salt = 32'h300;
        issue_load(32'h5000_0000, 1, 0);
        wait_pim_start(100);
        @(negedge i_clk);
        check_eq("compute_out_en", o_buf_out_en, 1);
        i_abort = 1'b1;
        pim_done_man = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        pim_done_man = 1'b0;
        #2;
        check_eq("abort_compute_done", o_done, 0);
        check_eq("abort_compute_out_en", o_buf_out_en, 0);
        check_eq("abort_compute_busy", o_busy, 0);
        pim_auto = 1'b1;

        // Start pulses during COMPUTE and alongside done are ignored
        salt = 32'h400;
        issue_load(32'h6000_0000, 1, 1);
        wait_pim_start(100);
        @(negedge i_clk);
        i_start = 1'b1;
        i_base_addr = $urandom;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(100);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        #2;
        check_eq("start_with_done_ignored", o_busy, 0);
        g0 = gnt_cnt;
        repeat (5) @(negedge i_clk);
        check_eq("no_extra_load", gnt_cnt - g0, 0);

        // Reset in REQ at idx 6, then a load whose addresses wrap
        gnt_max = 2;
        salt = 32'h500;
        issue_load(32'h4000_0000, 1, 1);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge i_clk);
            #2;
            got = o_mem_req && (o_buf_counter == 8'd6);
        end
        check_eq("reach_req_idx6", got, 1);
        i_rst_n = 1'b0;
        clear_expect();
        @(negedge i_clk);
        #2;
        check_eq("reset_mid_req", $countones(all_outs), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        gnt_max = 0;
        issue_load(32'hFFFF_FFF8, 1, 1);
        wait_done(100);

        // Randomized loads
        rand_dly = 1'b1;
        for (int n = 0; n < 6; n++) begin
            gnt_max = int'($urandom_range(3, 0));
            rv_max = 3;
            pim_dly = int'($urandom_range(6, 1));
            salt = $urandom;
            w0 = wr_cnt;
            issue_load($urandom, 1, 1);
            wait_done(400);
            check_eq("writes_random", wr_cnt - w0, NumWords);
        end

        repeat (3) @(negedge i_clk);
        check_eq("addr_queue_empty", exp_addr.size(), 0);
        check_eq("wr_queue_empty", exp_wr.size(), 0);
        check_eq("pim_queue_empty", exp_pim.size(), 0);
        check_eq("done_queue_empty", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
